cycle_sequencer: RTL

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

---
 rtl/cycle_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cycle_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/wb control with a
// single-level edge-triggered interrupt, RETI return path and absorbing halt.
module cycle_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic [5:0]  opcode,
  input  logic        rdMem,
  input  logic        wrMem,
  input  logic        wrReg,
  input  logic        mem_ready,
  output logic        ir_load,
  output logic        ifetch_en,
  output logic        rdMem_en,
  output logic        wrMem_en,
  output logic        wrReg_en,
  output logic        updPC,
  output logic [1:0]  pc_sel,
  output logic        epc_save,
  output logic        int_ack,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] retired
);

  localparam int unsigned OPW = 6;
  localparam logic [OPW-1:0] OP_HALT = 6'b111111;
  localparam logic [OPW-1:0] OP_RETI = 6'b111110;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_ISR = 2'b01;
  localparam logic [1:0] PC_EPC = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ISR    = 3'd5,
    S_HALT   = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  state_t cur, nxt;
  logic   int_q;
  logic   int_pending;
  logic   int_en;
  logic   retire;
  logic   reti;
  logic   int_edge;

  assign int_edge = INT & ~int_q;

  // Next-state and per-state control decode; reset forces every control low.
  always_comb begin
    nxt       = cur;
    retire    = 1'b0;
    reti      = 1'b0;
    ir_load   = 1'b0;
    ifetch_en = 1'b0;
    rdMem_en  = 1'b0;
    wrMem_en  = 1'b0;
    wrReg_en  = 1'b0;
    updPC     = 1'b0;
    pc_sel    = PC_SEQ;
    epc_save  = 1'b0;
    int_ack   = 1'b0;

    case (cur)
      S_FETCH: begin
        ifetch_en = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: nxt = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (opcode == OP_RETI) begin
          retire = 1'b1;
          reti   = 1'b1;
        end else if (rdMem | wrMem) begin
          nxt = S_MEM;
        end else if (wrReg) begin
          nxt = S_WB;
        end else begin
          retire = 1'b1;
        end
      end
      S_MEM: begin
        // Read takes priority so the two data enables never overlap.
        rdMem_en = rdMem;
        wrMem_en = wrMem & ~rdMem;
        if (mem_ready) begin
          if (rdMem & wrReg) nxt = S_WB;
          else               retire = 1'b1;
        end
      end
      S_WB: begin
        wrReg_en = 1'b1;
        retire   = 1'b1;
      end
      S_ISR: begin
        epc_save = 1'b1;
        int_ack  = 1'b1;
        updPC    = 1'b1;
        pc_sel   = PC_ISR;
        nxt      = S_FETCH;
      end
      S_HALT:  nxt = S_HALT;
      default: nxt = S_FETCH;
    endcase

    if (retire) begin
      updPC  = 1'b1;
      pc_sel = reti ? PC_EPC : PC_SEQ;
      nxt    = (int_pending && int_en) ? S_ISR : S_FETCH;
    end

    if (rst) begin
      ir_load   = 1'b0;
      ifetch_en = 1'b0;
      rdMem_en  = 1'b0;
      wrMem_en  = 1'b0;
      wrReg_en  = 1'b0;
      updPC     = 1'b0;
      pc_sel    = PC_SEQ;
      epc_save  = 1'b0;
      int_ack   = 1'b0;
    end
  end

  assign state  = cur;
  assign halted = (cur == S_HALT) && !rst;

  // State, interrupt bookkeeping and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= S_FETCH;
      int_q       <= 1'b0;
      int_pending <= 1'b0;
      int_en      <= 1'b1;
      retired     <= 32'd0;
    end else begin
      cur   <= nxt;
      int_q <= INT;
      // A fresh edge arriving during ISR is a new request and survives the clear.
      if (int_edge)            int_pending <= 1'b1;
      else if (cur == S_ISR)   int_pending <= 1'b0;
      if (cur == S_ISR)        int_en <= 1'b0;
      else if (retire && reti) int_en <= 1'b1;
      if (retire)              retired <= retired + 32'd1;
    end
  end

endmodule
